x_move_driver: RTL and testbench

Automatic X-player for the tic-tac-toe datapath: the transmit side of the `xin`/`Go` move interface that the game top consumes. It reads the registered board (`xin_star`, `oin_star`) and the status flags, and picks a free cell by sequential scan. It then drives a one-hot `xin` with a `Go` pulse and waits for the board registers to absorb the move. Used for self-play, regression and demo mode in place of a human X player.

---
 rtl/xmove_pkg.sv | 42 ++++
 rtl/cell_scan_lfsr.sv | 38 +++
 rtl/x_move_driver.sv | 183 ++++++++++++++++++
 tb/tb_x_move_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmove_pkg.sv
// ---------------------------------------------------------------------------
// xmove_pkg
// Shared types and constants for the automatic X-player (x_move_driver) and
// its scan start generator (cell_scan_lfsr).
//   xmove_state_t : driver FSM states
//   cell_idx_t    : 4-bit board cell index (0..8)
//   NUM_CELLS     : cells on the board
//   MAX_X_MOVES   : most moves X can make in one game
// ---------------------------------------------------------------------------
package xmove_pkg;

  localparam int NUM_CELLS   = 9;
  localparam int MAX_X_MOVES = 5;

  typedef logic [3:0] cell_idx_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } xmove_state_t;

  // One-hot board mask for a cell index.
  function automatic logic [NUM_CELLS-1:0] cell_onehot(input cell_idx_t c);
    logic [NUM_CELLS-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Scan order successor, wrapping the last cell back to cell 0.
  function automatic cell_idx_t next_cell(input cell_idx_t c);
    cell_idx_t n;
    if (c == cell_idx_t'(NUM_CELLS - 1)) n = '0;
    else                                  n = c + cell_idx_t'(1);
    return n;
  endfunction

endpackage

// File: rtl/cell_scan_lfsr.sv
// ---------------------------------------------------------------------------
// cell_scan_lfsr
// Start-index generator for the X-player's free-cell scan.
// Build option: XMOVE_RANDOM_EN
//   defined   : 4-bit maximal LFSR (x^4 + x^3 + 1), seeded to 4'b0001 on
//               reset, advancing every clock; start_idx = LFSR mod 9.
//   undefined : start_idx is constant 0 (lowest-free-cell policy), no state.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-low reset
//   start_idx out  cell index where the next scan begins (0..8)
// ---------------------------------------------------------------------------
module cell_scan_lfsr
  import xmove_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  output cell_idx_t start_idx
);

`ifdef XMOVE_RANDOM_EN
  logic [3:0] lfsr_reg;

  // Fibonacci form: feedback from taps 4 and 3; never reaches all-zero.
  always_ff @(posedge clock) begin
    if (!reset) lfsr_reg <= 4'b0001;
    else        lfsr_reg <= {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
  end

  assign start_idx = cell_idx_t'(lfsr_reg % 4'd9);
`else
  // Deterministic build: nothing clocked here, inputs intentionally idle.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clock, reset};
  assign start_idx     = '0;
`endif

endmodule

// File: rtl/x_move_driver.sv
// ---------------------------------------------------------------------------
// x_move_driver
// Automatic X player for the tic-tac-toe datapath. Scans the registered
// board for a free cell (one cell per cycle), presents it as a one-hot xin
// with a single-cycle Go strobe, then waits for xin_star to show the move.
// Build option: XMOVE_RANDOM_EN (randomised scan start, see cell_scan_lfsr).
// Parameter:
//   TIMEOUT       WAIT cycles allowed before the move is declared lost (2..255)
// Ports:
//   clock, reset  clock and synchronous active-low reset
//   start         one-cycle request to play a game / leave DONE or ERROR
//   xin_star      registered X board      oin_star  registered O board
//   playing_game  game still running      bad_move  game rejected the move
//   win_game, lose_game, draw_game        accepted but not decoded
//   xin           one-hot move (zero when no move is presented)
//   Go            move strobe, one cycle per move
//   busy          high in PICK/ISSUE/WAIT
//   done, error   high while in DONE / ERROR
//   move_count    moves issued this game (0..5)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module x_move_driver
  import xmove_pkg::*;
#(
  parameter int TIMEOUT = 15
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] xin_star,
  input  logic [8:0] oin_star,
  input  logic       playing_game,
  input  logic       win_game,
  input  logic       lose_game,
  input  logic       draw_game,
  input  logic       bad_move,
  output logic [8:0] xin,
  output logic       Go,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] move_count
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  xmove_state_t state_reg, state_next;
  cell_idx_t    scan_idx_reg, scan_idx_next;
  cell_idx_t    scan_cnt_reg, scan_cnt_next;
  cell_idx_t    cell_reg, cell_next;
  logic [7:0]   wait_cnt_reg, wait_cnt_next;
  logic [3:0]   move_count_reg, move_count_next;

  logic [8:0]   xin_reg;
  logic         go_reg, busy_reg, done_reg, error_reg;

  cell_idx_t    start_idx;
  logic [8:0]   occupied;

  // Result flags are visible to the bench only; playing_game alone ends a game.
  logic unused_status;
  assign unused_status = &{1'b0, win_game, lose_game, draw_game};

  assign occupied = xin_star | oin_star;

  cell_scan_lfsr u_scan (
    .clock     (clock),
    .reset     (reset),
    .start_idx (start_idx)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_next      = state_reg;
    scan_idx_next   = scan_idx_reg;
    scan_cnt_next   = scan_cnt_reg;
    cell_next       = cell_reg;
    wait_cnt_next   = wait_cnt_reg;
    move_count_next = move_count_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (playing_game) begin
            state_next      = S_PICK;
            move_count_next = '0;
            scan_idx_next   = start_idx;
            scan_cnt_next   = '0;
          end else begin
            state_next = S_DONE;
          end
        end
      end

      S_PICK: begin
        if (!occupied[scan_idx_reg]) begin
          cell_next  = scan_idx_reg;
          state_next = S_ISSUE;
          // Count lands with the Go cycle so move_count reads the new value
          // alongside the strobe.
          if (move_count_reg != 4'(MAX_X_MOVES))
            move_count_next = move_count_reg + 4'd1;
        end else if (scan_cnt_reg == cell_idx_t'(NUM_CELLS - 1)) begin
          // Ninth occupied cell in a row: board is full.
          state_next = S_DONE;
        end else begin
          scan_idx_next = next_cell(scan_idx_reg);
          scan_cnt_next = scan_cnt_reg + cell_idx_t'(1);
        end
      end

      S_ISSUE: begin
        state_next    = S_WAIT;
        wait_cnt_next = '0;
      end

      S_WAIT: begin
        // wait_cnt_next is the number of WAIT cycles including this one.
        wait_cnt_next = wait_cnt_reg + 8'd1;
        if (bad_move) begin
          state_next = S_ERROR;
        end else if (xin_star[cell_reg]) begin
          if (playing_game) begin
            state_next    = S_PICK;
            scan_idx_next = start_idx;
            scan_cnt_next = '0;
          end else begin
            state_next = S_DONE;
          end
        end else if (wait_cnt_next == TIMEOUT_CNT) begin
          state_next = S_ERROR;
        end
      end

      S_DONE, S_ERROR: begin
        if (start) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      scan_idx_reg   <= '0;
      scan_cnt_reg   <= '0;
      cell_reg       <= '0;
      wait_cnt_reg   <= '0;
      move_count_reg <= '0;
      xin_reg        <= '0;
      go_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      scan_idx_reg   <= scan_idx_next;
      scan_cnt_reg   <= scan_cnt_next;
      cell_reg       <= cell_next;
      wait_cnt_reg   <= wait_cnt_next;
      move_count_reg <= move_count_next;
      xin_reg        <= (state_next == S_ISSUE || state_next == S_WAIT)
                        ? cell_onehot(cell_next) : '0;
      go_reg         <= (state_next == S_ISSUE);
      busy_reg       <= (state_next == S_PICK) || (state_next == S_ISSUE) ||
                        (state_next == S_WAIT);
      done_reg       <= (state_next == S_DONE);
      error_reg      <= (state_next == S_ERROR);
    end
  end

  assign xin        = xin_reg;
  assign Go         = go_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign move_count = move_count_reg;

endmodule

// File: tb/tb_x_move_driver.sv
// ---------------------------------------------------------------------------
// tb_x_move_driver
// Directed and randomised stimulus for x_move_driver with a behavioural game
// model (board registers, random O player, win/draw detection).
// ---------------------------------------------------------------------------
module tb_x_move_driver;

  localparam int TO = 7;
`ifdef XMOVE_RANDOM_EN
  localparam int N_GAMES = 20;
`else
  localparam int N_GAMES = 6;
`endif

  localparam logic [8:0] LINES [8] = '{
    9'b000000111, 9'b000111000, 9'b111000000,
    9'b001001001, 9'b010010010, 9'b100100100,
    9'b100010001, 9'b001010100
  };

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [8:0] xin_star = '0;
  logic [8:0] oin_star = '0;
  logic       playing_game = 1'b0;
  logic       win_game = 1'b0, lose_game = 1'b0, draw_game = 1'b0;
  logic       bad_move = 1'b0;
  logic [8:0] xin;
  logic       Go, busy, done, error;
  logic [3:0] move_count;

  int n_checks = 0;
  int n_pass   = 0;

  bit         game_en     = 0;
  bit         ack_pending = 0;
  logic [8:0] ack_val     = '0;

  always #5 clock = ~clock;

  x_move_driver #(.TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .xin_star     (xin_star),
    .oin_star     (oin_star),
    .playing_game (playing_game),
    .win_game     (win_game),
    .lose_game    (lose_game),
    .draw_game    (draw_game),
    .bad_move     (bad_move),
    .xin          (xin),
    .Go           (Go),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .move_count   (move_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit has_line(input logic [8:0] b);
    for (int i = 0; i < 8; i++)
      if ((b & LINES[i]) == LINES[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowest_free(input logic [8:0] occ);
    for (int i = 0; i < 9; i++)
      if (!occ[i]) return i;
    return -1;
  endfunction

  function automatic logic [8:0] o_pick(input logic [8:0] occ);
    int free_idx[$];
    for (int i = 0; i < 9; i++)
      if (!occ[i]) free_idx.push_back(i);
`ifdef XMOVE_RANDOM_EN
    return 9'd1 << free_idx[0];
`else
    return 9'd1 << free_idx[$urandom_range(free_idx.size() - 1)];
`endif
  endfunction

  // Game register absorbs X's move, then the game answers with O.
  task automatic apply_x_move(input logic [8:0] mv);
    xin_star = xin_star | mv;
    if (has_line(xin_star)) begin
      playing_game = 1'b0; win_game = 1'b1;
    end else if ((xin_star | oin_star) == 9'h1FF) begin
      playing_game = 1'b0; draw_game = 1'b1;
    end else begin
      oin_star = oin_star | o_pick(xin_star | oin_star);
      if (has_line(oin_star)) begin
        playing_game = 1'b0; lose_game = 1'b1;
      end else if ((xin_star | oin_star) == 9'h1FF) begin
        playing_game = 1'b0; draw_game = 1'b1;
      end
    end
  endtask

  // One clock; outputs are stable when this returns (#1 after the edge).
  task automatic tick();
    @(posedge clock);
    #1;
    if (ack_pending) begin
      ack_pending = 0;
      apply_x_move(ack_val);
    end
    if (game_en && Go) begin
      ack_pending = 1;
      ack_val     = xin;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; bad_move = 1'b0;
    game_en = 0; ack_pending = 0;
    win_game = 1'b0; lose_game = 1'b0; draw_game = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // Preloaded board, one start pulse; checks first-move latency and cell,
  // then applies reset during WAIT.
  task automatic pattern_trial(input logic [8:0] xb, input logic [8:0] ob);
    int k, g;
    logic [8:0] occ;
    do_reset();
    xin_star = xb; oin_star = ob; playing_game = 1'b1;
    occ = xb | ob;
    k   = lowest_free(occ);
    g   = -1;
    start = 1'b1; tick(); start = 1'b0;   // now in cycle 1
    for (int c = 1; c <= 12; c++) begin
      if (Go) begin g = c; break; end
      if (c == 10 && k < 0) begin
        check("full_board_done", {31'd0, done}, 32'd1);
        check("full_board_busy", {31'd0, busy}, 32'd0);
      end
      tick();
    end
    if (k < 0) begin
      check("full_board_no_go", g, -1);
    end else begin
`ifdef XMOVE_RANDOM_EN
      check("first_go_seen", (g >= 1 && g <= 10), 1);
      check("first_xin_onehot_free", ($onehot(xin) && ((xin & occ) == 9'd0)), 1);
`else
      check("first_go_cycle", g, 2 + k);
      check("first_xin", xin, 9'd1 << k);
`endif
      check("first_move_count", move_count, 1);
      tick();   // WAIT
      check("wait_go_low", {31'd0, Go}, 32'd0);
      check("wait_xin_held", ($onehot(xin) && ((xin & occ) == 9'd0)), 1);
      check("wait_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0; tick(); reset = 1'b1;
      check("reset_in_wait_outputs", {xin, Go, busy, done, error, move_count}, 32'd0);
    end
  endtask

  initial begin
    int xm, fin;
    logic [8:0] xb, ob, occ;
    logic [8:0] seq_ref[$];
    logic [8:0] seq_cur[$];

    // Reset state.
    do_reset();
    check("reset_xin", xin, 0);
    check("reset_go", {31'd0, Go}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_error", {31'd0, error}, 0);
    check("reset_move_count", move_count, 0);

    // Directed first-move patterns, then random occupancies.
    pattern_trial(9'b000000000, 9'b000000000);
    pattern_trial(9'b000000101, 9'b000001010);
    pattern_trial(9'b101010101, 9'b010101010);
    for (int t = 0; t < 8; t++) begin
      xb = 9'($urandom) & 9'h1FF;
      ob = 9'($urandom) & ~xb;
      pattern_trial(xb, ob);
    end

    // No acknowledge: ERROR exactly TO cycles after WAIT entry (cycle 3).
    do_reset();
    xin_star = '0; oin_star = '0; playing_game = 1'b1;
    start = 1'b1; tick(); start = 1'b0;           // cycle 1
    check("to_pick_no_go", {31'd0, Go}, 0);
    tick();                                        // cycle 2
    check("to_issue_go", {31'd0, Go}, 1);
    for (int c = 3; c < 3 + TO; c++) tick();       // cycle 2+TO
    check("to_last_wait_no_error", {31'd0, error}, 0);
    check("to_last_wait_xin", xin, 9'd1);
    tick();                                        // cycle 3+TO
    check("to_error", {31'd0, error}, 1);
    check("to_error_xin", xin, 0);
    check("to_error_busy", {31'd0, busy}, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("error_exit_idle", {busy, done, error}, 0);
    tick();
    check("idle_stays_idle", {31'd0, busy}, 0);

    // Acknowledge arriving on the last WAIT cycle beats the timeout.
    do_reset();
    xin_star = '0; oin_star = '0; playing_game = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();                                        // cycle 2, Go
    for (int c = 3; c <= 2 + TO; c++) tick();      // cycle 2+TO
    xin_star = 9'd1; playing_game = 1'b0;
    tick();
    check("ack_vs_timeout_done", {done, error}, 2'b10);

    // bad_move wins over a simultaneous acknowledge.
    do_reset();
    xin_star = '0; oin_star = '0; playing_game = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();                                // cycle 3, WAIT
    bad_move = 1'b1; xin_star = 9'd1;
    tick();
    bad_move = 1'b0;
    check("bad_move_error", {done, error}, 2'b01);

    // start with no game running goes straight to DONE.
    do_reset();
    xin_star = '0; oin_star = '0; playing_game = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("start_not_playing_done", {busy, done}, 2'b01);

    // Full games against the game model.
    for (int g = 0; g < N_GAMES; g++) begin
      do_reset();
      xin_star = '0; oin_star = '0; playing_game = 1'b1;
      game_en = 1; xm = 0; fin = 0;
      seq_cur.delete();
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 300; c++) begin
        if (Go) begin
          xm++;
          occ = xin_star | oin_star;
          seq_cur.push_back(xin);
`ifdef XMOVE_RANDOM_EN
          check("game_xin_onehot_free", ($onehot(xin) && ((xin & occ) == 9'd0)), 1);
`else
          check("game_xin", xin, 9'd1 << lowest_free(occ));
`endif
          check("game_move_count", move_count, xm);
        end
        if (!playing_game && Go) check("game_go_after_end", {31'd0, Go}, 0);
        if (done || error) begin fin = 1; break; end
        tick();
      end
      check("game_finished", fin, 1);
      check("game_done_flag", {done, error}, 2'b10);
      check("game_final_count", move_count, xm);
      check("game_count_range", (move_count >= 3 && move_count <= 5), 1);
`ifdef XMOVE_RANDOM_EN
      if (g == 0) begin
        seq_ref = seq_cur;
      end else begin
        check("repeat_len", seq_cur.size(), seq_ref.size());
        for (int i = 0; i < seq_cur.size() && i < seq_ref.size(); i++)
          check("repeat_move", seq_cur[i], seq_ref[i]);
      end
`endif
      $display("game %0d: x_moves=%0d x=%b o=%b win=%0b lose=%0b draw=%0b",
               g, xm, xin_star, oin_star, win_game, lose_game, draw_game);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
